zone_frame_sched: RTL

Frame-level scheduler between the 360-zone backlight extractor and the LED driver link. It captures per-zone values (value, zone index, strobe) into a ping-pong buffer and validates each frame at vertical sync. It then streams one complete frame, zone 0..N_ZONES-1, over a valid/ready interface. Incomplete frames and frames arriving while a readout is busy are dropped and counted, so the driver never sees a torn frame.

---
 rtl/zone_pkg.sv | 13 +
 rtl/zone_pingpong_ram.sv | 29 ++
 rtl/zone_frame_sched.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/zone_pkg.sv
// Shared constants and read-FSM state encoding for the zone frame scheduler.
package zone_pkg;
  localparam int N_ZONES = 360;
  localparam int IDX_W   = 9;
  localparam int DW      = 8;
  localparam int CNT_W   = 8;

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, RD_MUL, HOLD} rd_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/zone_pingpong_ram.sv
// Two-bank zone buffer: one write port, one read port with a registered
// 1-cycle read. Both ports are addressed as {bank, zone index}.
module zone_pingpong_ram
  import zone_pkg::*;
(
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic             wr_bank_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [DW-1:0]    wr_data_i,
  input  logic             rd_bank_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [DW-1:0]    rd_data_o
);
  logic [DW-1:0] mem_q [2*N_ZONES];
  logic [DW-1:0] rd_data_q;
  logic [IDX_W:0] wr_addr, rd_addr;

  // Bank 1 sits directly after bank 0, so the array is exactly two frames deep.
  assign wr_addr = wr_bank_i ? (IDX_W+1)'(N_ZONES) + {1'b0, wr_idx_i} : {1'b0, wr_idx_i};
  assign rd_addr = rd_bank_i ? (IDX_W+1)'(N_ZONES) + {1'b0, rd_idx_i} : {1'b0, rd_idx_i};

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr] <= wr_data_i;
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/zone_frame_sched.sv
// Captures per-zone values into a ping-pong buffer, validates frames on sync
// rise and streams whole frames over valid/ready. GLOBAL_DIM_EN adds dim_gain.
//   state   | meaning
//   IDLE    | no readout, waiting for a complete frame
//   RD_ADDR | rd_ptr presented to the read bank
//   RD_DATA | RAM data available, captured into the output stage
//   RD_MUL  | gain product captured into the output stage (GLOBAL_DIM_EN)
//   HOLD    | beat presented, waiting for out_ready
module zone_frame_sched
  import zone_pkg::*;
(
  input  logic             i_pix_clk,
  input  logic             rst,
  input  logic             zone_valid,
  input  logic [IDX_W-1:0] zone_idx,
  input  logic [DW-1:0]    zone_val,
  input  logic             frame_sync,
`ifdef GLOBAL_DIM_EN
  input  logic [7:0]       dim_gain,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_sof,
  output logic             out_eof,
  output logic             busy,
  output logic [CNT_W-1:0] frame_err_cnt,
  output logic [CNT_W-1:0] overrun_cnt
);
  rd_state_e        state_q;
  logic             frame_sync_q, wr_bank_q, rd_bank_q;
  logic [IDX_W-1:0] wr_cnt_q, wr_cnt_inc, wr_cnt_d, rd_ptr_q;
  logic             out_valid_q, out_sof_q, out_eof_q;
  logic [DW-1:0]    out_data_q, ram_rd_data;
  logic [IDX_W-1:0] out_idx_q;
  logic [CNT_W-1:0] frame_err_q, overrun_q;
  logic             wr_en, sync_rise, frame_done;
`ifdef GLOBAL_DIM_EN
  logic [7:0]       gain_q;
  logic [15:0]      prod_q;
`endif

  always_comb begin
    wr_en      = zone_valid && (zone_idx < IDX_W'(N_ZONES));
    sync_rise  = frame_sync && !frame_sync_q;
    // A write coincident with the sync rise still belongs to the ending frame.
    wr_cnt_inc = (wr_en && (wr_cnt_q < IDX_W'(N_ZONES))) ? wr_cnt_q + 1'b1 : wr_cnt_q;
    frame_done = (wr_cnt_inc == IDX_W'(N_ZONES));
    wr_cnt_d   = sync_rise ? '0 : wr_cnt_inc;
  end

  zone_pingpong_ram u_ram (
    .clk_i     (i_pix_clk),
    .wr_en_i   (wr_en),
    .wr_bank_i (wr_bank_q),
    .wr_idx_i  (zone_idx),
    .wr_data_i (zone_val),
    .rd_bank_i (rd_bank_q),
    .rd_idx_i  (rd_ptr_q),
    .rd_data_o (ram_rd_data)
  );

  always_ff @(posedge i_pix_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      frame_sync_q <= 1'b0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b1;
      wr_cnt_q     <= '0;
      rd_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_sof_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      frame_err_q  <= '0;
      overrun_q    <= '0;
`ifdef GLOBAL_DIM_EN
      gain_q       <= '0;
      prod_q       <= '0;
`endif
    end else begin
      frame_sync_q <= frame_sync;
      wr_cnt_q     <= wr_cnt_d;
      if (sync_rise) begin
        if (!frame_done) begin
          frame_err_q <= sat_inc(frame_err_q);
        end else if (state_q == IDLE) begin
          wr_bank_q <= ~wr_bank_q;
          rd_bank_q <= ~rd_bank_q;
`ifdef GLOBAL_DIM_EN
          gain_q    <= dim_gain;
`endif
        end else begin
          overrun_q <= sat_inc(overrun_q);
        end
      end

      case (state_q)
        IDLE: if (sync_rise && frame_done) state_q <= RD_ADDR;
        RD_ADDR: state_q <= RD_DATA;
`ifdef GLOBAL_DIM_EN
        RD_DATA: begin
          prod_q  <= {8'b0, ram_rd_data} * ({8'b0, gain_q} + 16'd1);
          state_q <= RD_MUL;
        end
        RD_MUL: begin
          out_data_q  <= prod_q[15:8];
          out_idx_q   <= rd_ptr_q;
          out_sof_q   <= (rd_ptr_q == '0);
          out_eof_q   <= (rd_ptr_q == IDX_W'(N_ZONES-1));
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
`else
        RD_DATA: begin
          out_data_q  <= ram_rd_data;
          out_idx_q   <= rd_ptr_q;
          out_sof_q   <= (rd_ptr_q == '0);
          out_eof_q   <= (rd_ptr_q == IDX_W'(N_ZONES-1));
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
`endif
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (rd_ptr_q == IDX_W'(N_ZONES-1)) begin
              rd_ptr_q <= '0;
              state_q  <= IDLE;
            end else begin
              rd_ptr_q <= rd_ptr_q + 1'b1;
              state_q  <= RD_ADDR;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_idx       = out_idx_q;
  assign out_sof       = out_sof_q;
  assign out_eof       = out_eof_q;
  assign busy          = (state_q != IDLE);
  assign frame_err_cnt = frame_err_q;
  assign overrun_cnt   = overrun_q;
endmodule
